// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//
// Two-requester round-robin front end for a shared combinational ALU. A
// command from either requester is accepted through valid/ready. Its operands
// and opcode are registered onto the alu_* outputs, and the ALU is given one
// settle cycle (EXEC). The result is then captured and presented on the
// response port, tagged with the requester ID, and held until the consumer
// accepts it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req0_* / req1_*       command channels (valid/ready, a, b, op)
//   alu_a, alu_b, alu_op  registered operands/opcode to the external alu
//   alu_res               combinational result from the external alu
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_data      requester ID and captured result
//
// Optional feature (macro SCHED_GRANT_CNT_EN):
//   adds grant_cnt0 / grant_cnt1. These are 16-bit saturating counts of the
//   commands accepted from each requester.
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int DW  = 16,
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,

  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_res,

  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data
`ifdef SCHED_GRANT_CNT_EN
  ,
  output logic [15:0]    grant_cnt0,
  output logic [15:0]    grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;

  // Arbitration is evaluated every cycle. It only takes effect in IDLE.
  logic gnt_any;
  logic gnt_id;
  logic accept;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant;        // tie: the requester not served last
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign accept     = (state == IDLE) && gnt_any;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept &&  gnt_id;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;          // requester 0 wins the first tie
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            alu_a      <= gnt_id ? req1_a  : req0_a;
            alu_b      <= gnt_id ? req1_b  : req0_b;
            alu_op     <= gnt_id ? req1_op : req0_op;
            rsp_id     <= gnt_id;
            last_grant <= gnt_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // alu_* have been stable for a full cycle, so alu_res has settled.
          rsp_data  <= alu_res;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SCHED_GRANT_CNT_EN
  // Saturating per-requester acceptance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Two-requester round-robin scheduler that shares one combinational 16-bit `alu` (shift/SLT datapath, 6-bit opcode) between two clients. It accepts operand/opcode commands through valid/ready, drives registered operands into the ALU and allows one settle cycle. It then captures the ALU result and returns it, tagged with the requester ID, through a back-pressured response port. It sits between the instruction-issue logic and the `alu` instance; the `alu` is instantiated outside this block and connected through the `alu_*` ports.

Parameters:
DW, 16, operand/result width; must match the `alu` data width.
OPW, 6, opcode width; must match the `alu` opcode width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_a  input  DW  requester 0 operand 0.
- req0_b  input  DW  requester 0 operand 1.
- req0_op  input  OPW  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- alu_a  output  DW  registered operand 0 to the `alu`.
- alu_b  output  DW  registered operand 1 to the `alu`.
- alu_op  output  OPW  registered opcode to the `alu`.
- alu_res  input  DW  combinational result from the `alu`.
- rsp_valid  output  1  response holds a valid result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  ID of the requester that issued the result.
- rsp_data  output  DW  captured ALU result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - alu_a, alu_b, alu_op, rsp_data = 0.
  - rsp_valid = 0, rsp_id = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Any in-flight command is dropped and no response is produced for it.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - Grant rules:
    - Only one requester valid: that requester is granted.
    - Both valid: the requester not equal to last_grant is granted.
    - Neither valid: no grant; stay in IDLE.
  - reqN_ready is combinational, asserted only in IDLE for the granted requester. Both ready signals are never high together.
  - On a grant, at the clock edge:
    - alu_a, alu_b, alu_op <= the granted requester's operands and opcode.
    - rsp_id <= granted ID; last_grant <= granted ID.
    - state -> EXEC.
- EXEC (one cycle, ALU settle):
  - At the clock edge: rsp_data <= alu_res; rsp_valid <= 1; state -> HOLD.
- HOLD:
  - rsp_valid = 1; rsp_data, rsp_id, alu_* are held stable.
  - rsp_valid && rsp_ready: rsp_valid <= 0, state -> IDLE.
  - Otherwise stay in HOLD indefinitely.
- Latency: acceptance edge -> rsp_valid high 2 edges later. Minimum issue interval is 3 cycles with rsp_ready tied high.
- Requester rules:
  - A requester may drop valid before it sees ready; arbitration is re-evaluated every IDLE cycle.
  - Data is sampled only in the cycle where reqN_ready is high.
- Requests are never accepted in EXEC or HOLD; both reqN_ready signals stay 0 there.
- Widths: rsp_data is exactly DW bits of alu_res; no extension or truncation.

Optional Feature:
SCHED_GRANT_CNT_EN:
- Defined: adds two output ports, grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counter increments on every accepted command from its requester.
  - Counters saturate at 16'hFFFF and never wrap.
  - Both reset to 0 asynchronously with rst_n.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Single request, rsp_ready high:
   - Stimulus: req0 issues a=16'hdcf0, b=16'hdcf1, op=6'b100000.
   - Response: req0_ready high 1 cycle; alu_a=16'hdcf0 and alu_op=6'b100000 on the next edge; rsp_valid high 2 edges after acceptance; rsp_id=0; rsp_data equals `alu` output for those inputs.
2. Simultaneous requests:
   - Stimulus: req0 issues (16'h0001, 16'hdcf1, 6'b000011); req1 issues (16'h0001, 16'hdcf1, 6'b010011); both held valid.
   - Response: req0 is served first, then req1; rsp_id sequence 0,1; each rsp_data matches its own opcode's result.
3. Fairness:
   - Stimulus: both requesters valid continuously for 6 commands.
   - Response: rsp_id sequence 0,1,0,1,0,1; no two consecutive grants to the same requester.
4. Back-pressure:
   - Stimulus: rsp_ready held low for 5 cycles after rsp_valid rises, with req1 valid throughout.
   - Response: rsp_valid, rsp_data and rsp_id stay stable; req1_ready stays 0. When rsp_ready rises: handshake, return to IDLE, req1 granted in the next cycle.
5. Reset mid-operation:
   - Stimulus: assert rst_n low asynchronously while in EXEC.
   - Response: rsp_valid=0 and alu_a=alu_b=alu_op=0 immediately; after release, no response for the dropped command, and the first tie goes to req0.
6. SCHED_GRANT_CNT_EN defined:
   - Stimulus: 3 grants to req0 and 2 to req1.
   - Response: grant_cnt0=3, grant_cnt1=2. A counter preloaded to 16'hFFFF by force stays at 16'hFFFF after a further grant.
